// File: rtl/conv_input_feeder.sv
// conv_input_feeder: streams one feature tile and its kernel weights into a PARA_X x PARA_Y conv unit.
// Define FEEDER_PING_PONG_EN for double-banked tile/weight storage that accepts writes while streaming.
module conv_input_feeder #(
    parameter int DATA_WIDTH        = 16,
    parameter int PARA_X            = 3,
    parameter int PARA_Y            = 3,
    parameter int KERNEL_SIZE_MAX   = 5,
    parameter int KERNEL_SIZE_WIDTH = 4,
    localparam int TILE_AW = $clog2((PARA_X + KERNEL_SIZE_MAX - 1) * (PARA_Y + KERNEL_SIZE_MAX - 1)),
    localparam int WGT_AW  = $clog2(KERNEL_SIZE_MAX * KERNEL_SIZE_MAX)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [KERNEL_SIZE_WIDTH-1:0]        kernel_size,
    input  logic                                tile_wr_en,
    input  logic [TILE_AW-1:0]                  tile_wr_addr,
    input  logic [DATA_WIDTH-1:0]               tile_wr_data,
    input  logic                                weight_wr_en,
    input  logic [WGT_AW-1:0]                   weight_wr_addr,
    input  logic [DATA_WIDTH-1:0]               weight_wr_data,
    input  logic                                result_ready,
    output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] input_data,
    output logic [DATA_WIDTH-1:0]               weight,
    output logic                                conv_rst_n,
    output logic                                busy,
    output logic                                done,
    output logic                                cfg_err
);
    localparam int TILE_W = PARA_Y + KERNEL_SIZE_MAX - 1;
    localparam int TILE_N = (PARA_X + KERNEL_SIZE_MAX - 1) * TILE_W;
    localparam int WGT_N  = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
    localparam int CW     = $clog2(WGT_N);
`ifdef FEEDER_PING_PONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int TIW = $clog2(NB * TILE_N);
    localparam int WIW = $clog2(NB * WGT_N);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;

    state_t                       state_q, state_d;
    logic [KERNEL_SIZE_WIDTH-1:0] k_q, k_d;
    logic [CW-1:0]                c_q, c_d, r_q, r_d, s_q, s_d;
    logic [DATA_WIDTH-1:0]        weight_q, weight_d;
    logic                         cfg_err_q, cfg_err_d;
    logic                         legal, last, wrap, rd_bank, wr_bank, wr_ok;
    int                           ci, ri, si, ki, rd_tbase, rd_wbase, wr_tbase, wr_wbase;

    logic [DATA_WIDTH-1:0] tile_mem [NB*TILE_N];
    logic [DATA_WIDTH-1:0] w_mem    [NB*WGT_N];

`ifdef FEEDER_PING_PONG_EN
    logic bank_q, bank_d;
    assign bank_d  = bank_q ^ (state_q == IDLE && start && legal);
    assign rd_bank = bank_q;
    assign wr_bank = ~bank_q;
    assign wr_ok   = 1'b1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bank_q <= 1'b0;
        else      bank_q <= bank_d;
    end
`else
    assign rd_bank = 1'b0;
    assign wr_bank = 1'b0;
    assign wr_ok   = state_q == IDLE;
`endif

    assign ci       = int'(c_q);
    assign ri       = int'(r_q);
    assign si       = int'(s_q);
    assign ki       = int'(k_q);
    assign rd_tbase = rd_bank ? TILE_N : 0;
    assign rd_wbase = rd_bank ? WGT_N : 0;
    assign wr_tbase = wr_bank ? TILE_N : 0;
    assign wr_wbase = wr_bank ? WGT_N : 0;
    assign legal    = kernel_size == KERNEL_SIZE_WIDTH'(3) || kernel_size == KERNEL_SIZE_WIDTH'(5);
    assign last     = ci == ki * ki - 1;
    assign wrap     = si == ki - 1;

    always_ff @(posedge clk) begin
        if (tile_wr_en && wr_ok && int'(tile_wr_addr) < TILE_N)
            tile_mem[TIW'(wr_tbase + int'(tile_wr_addr))] <= tile_wr_data;
        if (weight_wr_en && wr_ok && int'(weight_wr_addr) < WGT_N)
            w_mem[WIW'(wr_wbase + int'(weight_wr_addr))] <= weight_wr_data;
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        c_d       = c_q;
        r_d       = r_q;
        s_d       = s_q;
        cfg_err_d = 1'b0;
        weight_d  = state_q == STREAM ? w_mem[WIW'(rd_wbase + ci)] : '0;
        case (state_q)
            IDLE: if (start) begin
                state_d   = legal ? STREAM : IDLE;
                k_d       = legal ? kernel_size : k_q;
                cfg_err_d = !legal;
            end
            STREAM: begin
                state_d = last ? WAIT : STREAM;
                c_d     = last ? '0 : c_q + 1'b1;
                r_d     = last ? '0 : (wrap ? r_q + 1'b1 : r_q);
                s_d     = (last || wrap) ? '0 : s_q + 1'b1;
            end
            WAIT:    state_d = result_ready ? DONE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // Word 0 of each PARA_Y group is the rightmost column of that group.
    always_comb begin
        input_data = '0;
        if (state_q == STREAM) begin
            if (ci == 0) begin
                for (int x = 0; x < PARA_X; x++)
                    for (int j = 0; j < PARA_Y; j++)
                        input_data[(x*PARA_Y + PARA_Y-1-j)*DATA_WIDTH +: DATA_WIDTH] =
                            tile_mem[TIW'(rd_tbase + x*TILE_W + j)];
            end else if (ci < ki) begin
                for (int x = 0; x < PARA_X; x++)
                    input_data[x*DATA_WIDTH +: DATA_WIDTH] =
                        tile_mem[TIW'(rd_tbase + x*TILE_W + PARA_Y-1 + ci)];
            end else if (si == 0) begin
                for (int j = 0; j < PARA_Y; j++)
                    input_data[(PARA_Y-1-j)*DATA_WIDTH +: DATA_WIDTH] =
                        tile_mem[TIW'(rd_tbase + (PARA_X-1 + ri)*TILE_W + j)];
            end else begin
                input_data[DATA_WIDTH-1:0] =
                    tile_mem[TIW'(rd_tbase + (PARA_X-1 + ri)*TILE_W + PARA_Y-1 + si)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            c_q       <= '0;
            r_q       <= '0;
            s_q       <= '0;
            weight_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            c_q       <= c_d;
            r_q       <= r_d;
            s_q       <= s_d;
            weight_q  <= weight_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign weight     = weight_q;
    assign cfg_err    = cfg_err_q;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign conv_rst_n = state_q == STREAM || state_q == WAIT;
endmodule

// File: tb/tb_conv_input_feeder.sv
// tb_conv_input_feeder: directed checks of conv_input_feeder with hand-computed vectors.
module tb_conv_input_feeder;
    localparam int DW = 16;
    localparam int NW = 9;
    typedef logic [NW*DW-1:0] vec_t;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, result_ready = 1'b0;
    logic [3:0]  kernel_size = 4'd0;
    logic        tile_wr_en = 1'b0, weight_wr_en = 1'b0;
    logic [5:0]  tile_wr_addr = '0;
    logic [4:0]  weight_wr_addr = '0;
    logic [15:0] tile_wr_data = '0, weight_wr_data = '0;
    vec_t        input_data;
    logic [15:0] weight;
    logic        conv_rst_n, busy, done, cfg_err;
    int          n_cmp = 0, n_bad = 0;
    vec_t        k3_vec [9];

    always #5 clk = ~clk;

    conv_input_feeder dut (
        .clk(clk), .rst(rst), .start(start), .kernel_size(kernel_size),
        .tile_wr_en(tile_wr_en), .tile_wr_addr(tile_wr_addr), .tile_wr_data(tile_wr_data),
        .weight_wr_en(weight_wr_en), .weight_wr_addr(weight_wr_addr), .weight_wr_data(weight_wr_data),
        .result_ready(result_ready), .input_data(input_data), .weight(weight),
        .conv_rst_n(conv_rst_n), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ctl = {busy, conv_rst_n, done, cfg_err}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, vec_t'({busy, conv_rst_n, done, cfg_err}), vec_t'(exp));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_k3(input string pfx);
        kernel_size = 4'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("%s data c=%0d", pfx, c), input_data, k3_vec[c]);
            chk($sformatf("%s weight c=%0d", pfx, c), vec_t'(weight), vec_t'(c == 0 ? 0 : c - 1));
            chk_ctl($sformatf("%s ctl c=%0d", pfx, c), 4'b1100);
            result_ready = (c == 4);
            tick;
        end
        result_ready = 1'b0;
        chk($sformatf("%s wait1 weight", pfx), vec_t'(weight), vec_t'(8));
        chk($sformatf("%s wait1 data", pfx), input_data, '0);
        kernel_size = 4'd5;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk($sformatf("%s wait2 weight", pfx), vec_t'(weight), '0);
        chk_ctl($sformatf("%s wait2 ctl", pfx), 4'b1100);
        tick;
        tick;
        chk_ctl($sformatf("%s wait4 ctl", pfx), 4'b1100);
        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
        chk_ctl($sformatf("%s done ctl", pfx), 4'b1010);
        chk($sformatf("%s done data", pfx), input_data, '0);
        tick;
        chk_ctl($sformatf("%s idle ctl", pfx), 4'b0000);
    endtask

    initial begin
        k3_vec[0] = {16'h20, 16'h21, 16'h22, 16'h10, 16'h11, 16'h12, 16'h00, 16'h01, 16'h02};
        k3_vec[1] = {96'h0, 16'h23, 16'h13, 16'h03};
        k3_vec[2] = {96'h0, 16'h24, 16'h14, 16'h04};
        k3_vec[3] = {96'h0, 16'h30, 16'h31, 16'h32};
        k3_vec[4] = {128'h0, 16'h33};
        k3_vec[5] = {128'h0, 16'h34};
        k3_vec[6] = {96'h0, 16'h40, 16'h41, 16'h42};
        k3_vec[7] = {128'h0, 16'h43};
        k3_vec[8] = {128'h0, 16'h44};

        #1;
        chk_ctl("reset ctl", 4'b0000);
        chk("reset data", input_data, '0);
        chk("reset weight", vec_t'(weight), '0);
        tick;
        tick;
        rst = 1'b1;

        tile_wr_en = 1'b1;
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++) begin
                tile_wr_addr = 6'(i * 7 + j);
                tile_wr_data = 16'(i * 16 + j);
                tick;
            end
        tile_wr_en = 1'b0;
        weight_wr_en = 1'b1;
        for (int n = 0; n < 25; n++) begin
            weight_wr_addr = 5'(n);
            weight_wr_data = 16'(n);
            tick;
        end
        weight_wr_en = 1'b0;

        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
        chk_ctl("rr idle ctl", 4'b0000);
        tick;
        chk_ctl("rr idle ctl2", 4'b0000);

        run_k3("k3");

        kernel_size = 4'd4;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk_ctl("k4 cfg_err", 4'b0001);
        tick;
        chk_ctl("k4 after", 4'b0000);

        kernel_size = 4'd5;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 25; c++) begin
            chk($sformatf("k5 weight c=%0d", c), vec_t'(weight), vec_t'(c == 0 ? 0 : c - 1));
            if (c == 0) chk("k5 data c=0", input_data, k3_vec[0]);
            if (c == 4) chk("k5 data c=4", input_data, {96'h0, 16'h26, 16'h16, 16'h06});
            if (c == 5) chk("k5 data c=5", input_data, k3_vec[3]);
            if (c == 7) chk("k5 data c=7", input_data, {128'h0, 16'h34});
            if (c == 24) chk("k5 data c=24", input_data, {128'h0, 16'h66});
            tick;
        end
        chk("k5 wait1 weight", vec_t'(weight), vec_t'(24));
        chk_ctl("k5 wait1 ctl", 4'b1100);
        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
        chk_ctl("k5 done ctl", 4'b1010);
        tick;
        chk_ctl("k5 idle ctl", 4'b0000);

        kernel_size = 4'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tile_wr_en = (c < 3);
            tile_wr_addr = 6'(c);
            tile_wr_data = 16'(16'h0B00 + c);
            weight_wr_en = (c == 0);
            weight_wr_addr = 5'd1;
            weight_wr_data = 16'h00B1;
            if (c < 5) tick;
        end
        tile_wr_en = 1'b0;
        weight_wr_en = 1'b0;
        chk("abort data c=5", input_data, k3_vec[5]);
        chk("abort weight c=5", vec_t'(weight), vec_t'(4));
        #2;
        rst = 1'b0;
        #1;
        chk_ctl("abort ctl", 4'b0000);
        chk("abort data", input_data, '0);
        chk("abort weight", vec_t'(weight), '0);
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk_ctl("post-abort ctl", 4'b0000);

        run_k3("replay");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_input_feeder.md
CONV_INPUT_FEEDER -- requirements
Module: conv_input_feeder

Interface
REQ-001 Parameter DATA_WIDTH, 16, bits per float16 element.
REQ-002 Parameter PARA_X, 3, number of output rows computed in parallel.
REQ-003 Parameter PARA_Y, 3, number of output columns computed in parallel.
REQ-004 Parameter KERNEL_SIZE_MAX, 5, largest supported kernel; TILE_H=PARA_X+KERNEL_SIZE_MAX-1 and TILE_W=PARA_Y+KERNEL_SIZE_MAX-1.
REQ-005 Parameter KERNEL_SIZE_WIDTH, 4, width of kernel_size.
REQ-006 clk  in  1  sole clock; all logic is on the rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset (0: reset; 1: none).
REQ-008 start  in  1  one-cycle request to stream one tile; honoured only in IDLE.
REQ-009 kernel_size  in  KERNEL_SIZE_WIDTH  kernel size K; only 3 and 5 are legal; latched when start is accepted.
REQ-010 tile_wr_en / tile_wr_addr / tile_wr_data  in  1 / clog2(TILE_H*TILE_W) / DATA_WIDTH  tile write port; addr = row*TILE_W+col.
REQ-011 weight_wr_en / weight_wr_addr / weight_wr_data  in  1 / clog2(KMAX^2) / DATA_WIDTH  weight write port; addr = r*K+s.
REQ-012 result_ready  in  1  pulse from the downstream convolution unit.
REQ-013 input_data  out  PARA_X*PARA_Y*DATA_WIDTH  per-cycle feature data to the convolution unit.
REQ-014 weight  out  DATA_WIDTH  per-cycle weight to the convolution unit.
REQ-015 conv_rst_n  out  1  active-low reset driven to the convolution unit.
REQ-016 busy / done / cfg_err  out  1 each  busy is high outside IDLE; done is a one-cycle pulse; cfg_err is a one-cycle pulse on an illegal K.

Function
REQ-017 The FSM SHALL have four states: IDLE -> (start, legal K) STREAM -> (c==K*K-1) WAIT -> (result_ready) DONE -> IDLE.
REQ-018 The cycle counter c SHALL run 0..K*K-1 in STREAM, with kernel position r=c/K and s=c%K.
REQ-019 conv_rst_n SHALL be 0 in IDLE and DONE, and SHALL be 1 in STREAM and WAIT; it rises on the same edge that enters STREAM.
REQ-020 Word ordering: in every PARA_Y-word group, word 0 (LSB) holds the rightmost column and word PARA_Y-1-j holds column j.
REQ-021 At c=0, group x (x=0..PARA_X-1) SHALL carry tile[x][0..PARA_Y-1].
REQ-022 At 0<c<K, word x SHALL carry tile[x][PARA_Y-1+c].
REQ-023 At c>0 with s==0, group 0 SHALL carry tile[PARA_X-1+r][0..PARA_Y-1].
REQ-024 For all other c, word 0 SHALL carry tile[PARA_X-1+r][PARA_Y-1+s].
REQ-025 Every input_data word not assigned by REQ-021..024 SHALL be driven 0.
REQ-026 input_data SHALL be 0 outside STREAM.
REQ-027 weight SHALL lag input_data by one cycle: W[c-1] in STREAM cycle c>0, W[K*K-1] in the first WAIT cycle, and 0 otherwise.
REQ-028 WAIT SHALL hold input_data and weight at 0 until result_ready, with no timeout.
REQ-029 DONE SHALL last exactly one cycle, with done=1 in that cycle.
REQ-030 An illegal K with start in IDLE SHALL pulse cfg_err the next cycle and remain in IDLE.
REQ-031 start SHALL be ignored while busy.
REQ-032 result_ready outside WAIT SHALL be ignored.
REQ-033 A tile or weight write during STREAM/WAIT SHALL be dropped unless FEEDER_PING_PONG_EN is defined.
REQ-034 Reads and writes to the same address in the same cycle SHALL return the old data.

Reset
REQ-035 On rst=0, the block SHALL immediately enter IDLE with c=0, conv_rst_n=0, input_data=0, weight=0, busy=0, done=0 and cfg_err=0.
REQ-036 Reset mid-STREAM SHALL abort the tile, and no done is produced.
REQ-037 Tile and weight storage SHALL NOT be cleared by reset.

Configuration
REQ-038 With FEEDER_PING_PONG_EN defined, the tile and weight buffers SHALL be two banks: writes go to the inactive bank, and the banks swap on each accepted start.
REQ-039 Without FEEDER_PING_PONG_EN, the buffers SHALL be a single bank and REQ-033 applies.

Verification
REQ-040 K=3, tile[i][j]=i*16+j, W[n]=n, start -> 9 STREAM cycles; at c=1, input_data words 0/1/2 = 0x03/0x13/0x23; at c=3, word 0..2 = 0x32/0x31/0x30; weight 0..8 follows one cycle behind; result_ready after 4 WAIT cycles -> done=1 for one cycle and conv_rst_n=0.
REQ-041 K=5, same tile -> 25 STREAM cycles; at c=7 (r=1, s=2), word 0 = 0x34 and all other words = 0; at c=24, word 0 = 0x66.
REQ-042 kernel_size=4 with start -> cfg_err=1 for one cycle, busy stays 0, conv_rst_n stays 0.
REQ-043 rst=0 asserted at c=5 -> all outputs 0 at once; a later start with K=3 replays from c=0 with the original tile data.
REQ-044 FEEDER_PING_PONG_EN: write tile B during stream of tile A; a second start streams B with c=0 group 0 = B[0][0..2]; without the macro the same writes are dropped and A is replayed.
REQ-045 result_ready pulsed in IDLE and in STREAM -> no state change and no done.
